// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit common-anode 7-segment display.
// Software writes a shadow copy of eight hex digits (+ decimal points); a commit
// copies shadow to the active copy at the next frame boundary so a frame never tears.
// The active copy is time-multiplexed onto dig/segm at CLK_DIV clocks per digit.
// Optional feature: define SEG_LZ_BLANK_EN to enable leading-zero suppression.

`timescale 1ns/1ps

module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV = 50000,  // clocks per digit slot, >= 2
    parameter int unsigned PW      = 16      // prescaler width, 2^PW >= CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    output logic       wr_ready,
    input  logic       commit,
    output logic       commit_pending,
    input  logic       blank,
    output logic [7:0] dig,
    output logic [7:0] segm,
    output logic       frame_tick
);

    localparam logic [PW-1:0] PreLast = PW'(CLK_DIV - 1);

    // Each digit entry is {dp, nibble}.
    logic [PW-1:0]   pre_q, pre_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0][4:0] shadow_q, shadow_d;
    logic [7:0][4:0] active_q, active_d;
    logic            pending_q, pending_d;
    logic [7:0]      dig_q, dig_d;
    logic [7:0]      segm_q, segm_d;

    logic terminal;
    logic boundary;
    logic xfer;
    logic lz_blank;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign terminal = (pre_q == PreLast);
    assign boundary = terminal && (idx_q == 3'd7);
    // A transfer cycle owns the shadow copy, so writes stall for that one cycle.
    assign xfer     = boundary && pending_q;

    // Prescaler and digit index advance.
    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (terminal) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Shadow writes, frame-synchronous transfer and the commit request flag.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_en && !xfer) begin
            shadow_d[wr_addr] = {wr_dp, wr_data};
        end
        if (xfer) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Digit k is suppressed when it and all digits above it are zero with dp off.
    logic [7:0] lz_zero;
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_zero = '0;
        for (int k = 7; k >= 0; k--) begin
            run        = run && (active_q[k] == 5'd0);
            lz_zero[k] = run;
        end
        lz_blank = (idx_q != 3'd0) && lz_zero[idx_q];
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Next registered anode/segment drive for the current index.
    always_comb begin
        dig_d  = 8'hFF;
        segm_d = 8'hFF;
        if (!blank) begin
            dig_d = ~(8'h01 << idx_q);
            if (!lz_blank) begin
                segm_d = {~active_q[idx_q][4], hex_decode(active_q[idx_q][3:0])};
            end
        end
    end

    // Scan position state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // Digit storage and commit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Registered display outputs, dark in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q  <= 8'hFF;
            segm_q <= 8'hFF;
        end else begin
            dig_q  <= dig_d;
            segm_q <= segm_d;
        end
    end

    assign dig            = dig_q;
    assign segm           = segm_q;
    assign frame_tick     = boundary;
    assign wr_ready       = ~xfer;
    assign commit_pending = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (CLK_DIV=4). Reference model derives scan position
// from a cycle count since reset release and keeps shadow/active digit arrays.
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

    localparam int CDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       wr_ready;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic       blank = 1'b0;
    logic [7:0] dig;
    logic [7:0] segm;
    logic       frame_tick;

    int n_pass  = 0;
    int n_total = 0;

    seg_scan_ctrl #(.CLK_DIV(CDIV), .PW(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .wr_ready(wr_ready), .commit(commit), .commit_pending(commit_pending),
        .blank(blank), .dig(dig), .segm(segm), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int         t;                 // clock edges since reset release
    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];
    bit         m_pending;
    logic [7:0] exp_dig, exp_segm;

    function automatic bit m_bnd();
        return ((t % CDIV) == CDIV - 1) && (((t / CDIV) % 8) == 7);
    endfunction

    function automatic logic [7:0] ref_segm(input int ix);
        logic [7:0] s;
`ifdef SEG_LZ_BLANK_EN
        bit all_zero;
        all_zero = (ix != 0);
        for (int j = ix; j < 8; j++) if (m_active[j] != 5'd0) all_zero = 0;
        if (all_zero) return 8'hFF;
`endif
        s = seg_tab[m_active[ix][3:0]];
        if (m_active[ix][4]) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [18:0] exp_now();
        return {exp_dig, exp_segm, m_bnd(), !(m_bnd() && m_pending), m_pending};
    endfunction

    task automatic model_reset();
        t = 0;
        m_pending = 0;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        exp_dig  = 8'hFF;
        exp_segm = 8'hFF;
    endtask

    // Advance model and DUT by one clock using the currently driven inputs.
    task automatic tick();
        int ix;
        bit xfer;
        ix   = (t / CDIV) % 8;
        xfer = m_bnd() && m_pending;
        exp_dig  = blank ? 8'hFF : ~(8'h01 << ix);
        exp_segm = blank ? 8'hFF : ref_segm(ix);
        if (wr_en && !xfer) m_shadow[wr_addr] = {wr_dp, wr_data};
        if (xfer) m_active = m_shadow;
        m_pending = xfer ? 1'b0 : (commit ? 1'b1 : m_pending);
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Write one digit, holding the request until the DUT accepts it.
    task automatic write_digit(input int a, input int d, input bit dp);
        bit acc;
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(d); wr_dp = dp;
        for (int k = 0; k < 4; k++) begin
            acc = wr_ready;
            tick();
            if (acc) break;
        end
        wr_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [18:0] obs;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        obs = {dig, segm, frame_tick, wr_ready, commit_pending};
        if (obs !== {8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state: got %h want %h", obs, {8'hFF, 8'hFF, 3'b010});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 70; c++) begin
            tick();
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL reset_scan t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
    endtask

    task automatic test_commit();
        logic [18:0] obs;
        logic [7:0]  want [8] = '{8'hF9, 8'hA4, 8'h30, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
        for (int i = 0; i < 8; i++) write_digit(i, i + 1, i == 2);
        while ((t % 32) != 13) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int c = 0; c < 40 && !frame_tick; c++) begin
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL commit_hold t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
            tick();
        end
        n_total++;
        if ({frame_tick, commit_pending} !== 2'b11)
            $display("FAIL commit_boundary: got %b want 11", {frame_tick, commit_pending});
        else n_pass++;
        tick();
        for (int d = 0; d < 8; d++) begin
            tick();
            n_total++;
            if ({dig, segm, commit_pending} !== {~(8'h01 << d), want[d], 1'b0})
                $display("FAIL commit_frame d=%0d: got %h_%h_%b want %h_%h_0", d, dig, segm,
                         commit_pending, ~(8'h01 << d), want[d]);
            else n_pass++;
            for (int k = 0; k < CDIV - 1; k++) tick();
        end
    endtask

    task automatic test_stall();
        logic [18:0] obs;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int c = 0; c < 40 && !m_bnd(); c++) tick();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hA; wr_dp = 1'b0;
        n_total++;
        if ({frame_tick, wr_ready} !== 2'b10)
            $display("FAIL stall_ready_low: got %b want 10", {frame_tick, wr_ready});
        else n_pass++;
        tick();
        n_total++;
        if (wr_ready !== 1'b1) $display("FAIL stall_ready_back: got %b want 1", wr_ready);
        else n_pass++;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 40) commit = 1'b1;
            tick();
            commit = 1'b0;
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL stall_follow t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
    endtask

    task automatic test_blank();
        logic [18:0] obs;
        int gap;
        for (int c = 0; c < 40 && !frame_tick; c++) tick();
        gap = 0;
        for (int c = 0; c < 5; c++) begin tick(); gap++; end
        blank = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            gap++;
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now() || {dig, segm} !== 16'hFFFF)
                $display("FAIL blank_dark t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
        blank = 1'b0;
        for (int c = 0; c < 40 && !frame_tick; c++) begin
            tick();
            gap++;
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL blank_resume t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
        n_total++;
        if (gap !== 32) $display("FAIL blank_tick_gap: got %0d want 32", gap);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [18:0] obs;
        for (int i = 0; i < 8; i++) write_digit(i, 15 - i, 1'b1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({dig, segm, commit_pending} !== {8'hFF, 8'hFF, 1'b0})
            $display("FAIL reset_async: got %h_%h_%b want FF_FF_0", dig, segm, commit_pending);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c == 20) commit = 1'b1;
            tick();
            commit = 1'b0;
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now() || (c > 0 && segm !== 8'hC0))
                $display("FAIL reset_mid t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
    endtask

    task automatic test_lz();
        logic [18:0] obs;
        for (int i = 0; i < 8; i++) write_digit(i, 0, 1'b0);
        write_digit(0, 5, 1'b0);
        write_digit(2, 3, 1'b0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL lz_frame t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [18:0] obs;
        for (int c = 0; c < 1500; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            wr_dp   = ($urandom_range(0, 3) == 0);
            commit  = ($urandom_range(0, 19) == 0);
            blank   = ($urandom_range(0, 15) == 0);
            if ((c % 300) == 150) begin
                wr_en = 1'b0;
                for (int i = 0; i < 8; i++) m_shadow[i] = m_shadow[i];
            end
            tick();
            n_total++;
            obs = {dig, segm, frame_tick, wr_ready, commit_pending};
            if (obs !== exp_now()) $display("FAIL random t=%0d: got %h want %h", t, obs, exp_now());
            else n_pass++;
        end
        wr_en = 1'b0; commit = 1'b0; blank = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_stall();
        test_blank();
        test_reset_mid();
        test_lz();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
